alu_arbiter: RTL and testbench

Shares the single 32-bit ALU between two requesters (port 0: main datapath, port 1: address/branch helper) under round-robin arbitration. Each request is accepted with a valid/ready handshake, executed on one internal ALU instance from registered operands, and returned to its originator with a valid/ready response handshake. Only one operation is in flight at a time.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_arbiter_alu.sv | 23 ++
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width, opcode and FSM state definitions for the ALU arbiter
package alu_pkg;
  localparam int DATA_WIDTH = 32;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_LUI = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU shared by both arbiter ports
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         zero
);
  // Only ADD and LUI are implemented; every other code yields zero.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_LUI:  result[31:12] = b[19:0];
      default: result = '0;
    endcase
    zero = (result == '0);
  end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [3:0]            req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [3:0]            req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_result_o,
  output logic                  rsp0_zero_o,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_result_o,
  output logic                  rsp1_zero_o,
  output logic                  busy_o
);
  state_t                state, state_nxt;
  logic                  last_grant, gnt_id;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, result_q;
  logic                  zero_q;
  logic                  grant0, grant1, accept, rsp_take;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;

  // Contention goes to the port that was not served last.
  always_comb begin
    grant0   = req0_valid_i & (~req1_valid_i | last_grant);
    grant1   = req1_valid_i & (~req0_valid_i | ~last_grant);
    accept   = (state == ST_IDLE) & (grant0 | grant1);
    rsp_take = (state == ST_RESP) & (gnt_id ? rsp1_ready_i : rsp0_ready_i);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_take) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      if (accept) begin
        gnt_id <= grant1;
        op_q   <= grant1 ? req1_op_i : req0_op_i;
        a_q    <= grant1 ? req1_a_i  : req0_a_i;
        b_q    <= grant1 ? req1_b_i  : req0_b_i;
      end
      if (state == ST_EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
      if (rsp_take) last_grant <= gnt_id;
    end
  end

  alu_arbiter_alu #(.W(DATA_WIDTH)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign req0_ready_o  = (state == ST_IDLE) & grant0;
  assign req1_ready_o  = (state == ST_IDLE) & grant1;
  assign rsp0_valid_o  = (state == ST_RESP) & ~gnt_id;
  assign rsp1_valid_o  = (state == ST_RESP) & gnt_id;
  assign rsp0_result_o = result_q;
  assign rsp1_result_o = result_q;
  assign rsp0_zero_o   = zero_q;
  assign rsp1_zero_o   = zero_q;
  assign busy_o        = (state != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a transaction-level reference model
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  v, rr;
  logic [3:0]  op [2];
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic        r0, r1, rv0, rv1, z0, z1, busy;
  logic [31:0] res0, res1;
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        zero;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(v[0]), .req0_ready_o(r0), .req0_op_i(op[0]), .req0_a_i(a[0]), .req0_b_i(b[0]),
    .req1_valid_i(v[1]), .req1_ready_o(r1), .req1_op_i(op[1]), .req1_a_i(a[1]), .req1_b_i(b[1]),
    .rsp0_valid_o(rv0), .rsp0_ready_i(rr[0]), .rsp0_result_o(res0), .rsp0_zero_o(z0),
    .rsp1_valid_o(rv1), .rsp1_ready_i(rr[1]), .rsp1_result_o(res1), .rsp1_zero_o(z1),
    .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o == 4'b0000) return x + y;
    if (o == 4'b0100) return y << 12;
    return 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic got;
    got = 1'b0;
    op[p] = o; a[p] = x; b[p] = y; v[p] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? r0 : r1) got = 1'b1;
    end
    chk("send_accept_timeout", {31'd0, got}, 32'd1);
    tick();
    v[p] = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rv"}, {30'd0, rv1, rv0}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_res0"}, res0, 32'd0);
    chk({name, "_res1"}, res1, 32'd0);
    chk({name, "_zero"}, {30'd0, z1, z0}, 32'd0);
  endtask

  // Reference model: one transaction at a time, round-robin on contention.
  initial begin
    logic       m_busy, m_last, p;
    logic [1:0] g;
    int         m_age;
    exp_t       e;
    m_busy = 1'b0; m_last = 1'b1; m_age = 0; p = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_busy = 1'b0; m_last = 1'b1; m_age = 0;
      end else begin
        chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
        if (!m_busy) begin
          if (v == 2'b11) g = m_last ? 2'b01 : 2'b10;
          else            g = v;
          chk("model_ready", {30'd0, r1, r0}, {30'd0, g});
          if (g != 2'b00) begin
            p = g[1];
            e.port = p;
            e.res  = ref_res(op[p], a[p], b[p]);
            e.zero = (e.res == 32'd0);
            e.cyc  = cyc;
            exp_q.push_back(e);
            m_busy = 1'b1; m_age = 0;
          end
        end else begin
          chk("model_ready_busy", {30'd0, r1, r0}, 32'd0);
          m_age++;
          if (m_age >= 2 && rr[p]) begin
            m_busy = 1'b0; m_last = p;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every completed response handshake.
  initial begin
    logic [1:0] prev;
    logic       vld, rdy, zz;
    logic [31:0] rs;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        prev = 2'b00;
      end else begin
        for (int q = 0; q < 2; q++) begin
          vld = (q == 0) ? rv0 : rv1;
          rdy = rr[q];
          rs  = (q == 0) ? res0 : res1;
          zz  = (q == 0) ? z0 : z1;
          if (vld) begin
            if (exp_q.size() == 0 || exp_q[0].port != q[0]) begin
              n_total++; n_bad++;
              $display("FAIL rsp_unexpected: port %0d got valid=1 expected valid=0 (t=%0t)", q, $time);
            end else begin
              if (!prev[q]) chk("rsp_latency", cyc - exp_q[0].cyc, 32'd2);
              chk("rsp_result", rs, exp_q[0].res);
              chk("rsp_zero", {31'd0, zz}, {31'd0, exp_q[0].zero});
              if (rdy) void'(exp_q.pop_front());
            end
          end
          prev[q] = vld;
        end
      end
    end
  end

  initial begin
    logic [3:0] ops [8];
    logic [1:0] acc;
    int         k;
    ops = '{4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b1111};
    reset = 1'b0; v = 2'b00; rr = 2'b00;
    for (int i = 0; i < 2; i++) begin op[i] = 4'd0; a[i] = 32'd0; b[i] = 32'd0; end
    repeat (3) tick();
    chk_all_zero("reset");
    chk("reset_ready", {30'd0, r1, r0}, 32'd0);
    reset = 1'b1;
    tick();

    rr = 2'b11;
    send(0, 4'b0000, 32'd5, 32'd7);
    repeat (3) tick();
    send(1, 4'b0100, 32'd0, 32'h000ABCDE);
    send(0, 4'b0000, 32'h7FFFFFFF, 32'd1);
    send(0, 4'b0001, 32'd9, 32'd4);
    send(1, 4'b0000, -32'sd3, 32'd3);
    repeat (3) tick();

    // Continuous contention must alternate starting with port 0.
    v = 2'b11;
    for (int i = 0; i < 2; i++) begin op[i] = 4'b0000; a[i] = $urandom; b[i] = $urandom; end
    k = 0;
    for (int c = 0; c < 100 && k < 8; c++) begin
      @(negedge clk);
      acc = {r1, r0};
      if (acc != 2'b00) begin
        chk("alt_grant", {31'd0, r1}, k % 2);
        k++;
      end
      tick();
      for (int i = 0; i < 2; i++) if (acc[i]) begin a[i] = $urandom; b[i] = $urandom; end
    end
    v = 2'b00;
    chk("alt_count", k, 32'd8);
    repeat (4) tick();

    // Response backpressure on port 0 with port 1 waiting.
    rr = 2'b00;
    send(0, 4'b0000, 32'd100, 32'd23);
    op[1] = 4'b0000; a[1] = 32'd1; b[1] = 32'd2; v[1] = 1'b1;
    tick();
    repeat (10) begin
      @(negedge clk);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      chk("bp_req1_ready", {31'd0, r1}, 32'd0);
      chk("bp_hold", res0, 32'd123);
      tick();
    end
    rr = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_req1", {31'd0, r1}, 32'd1);
    tick();
    v[1] = 1'b0;
    repeat (4) tick();

    // Reset during EXEC.
    send(0, 4'b0000, 32'd1, 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_exec");
    tick(); tick();
    reset = 1'b1;
    repeat (4) tick();

    // Reset during RESP.
    rr = 2'b00;
    send(1, 4'b0100, 32'd0, 32'd5);
    tick();
    chk("rst_resp_pre_valid", {31'd0, rv1}, 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_resp");
    tick(); tick();
    reset = 1'b1;
    rr = 2'b11;
    repeat (4) tick();
    v = 2'b11;
    for (int i = 0; i < 2; i++) begin op[i] = 4'b0000; a[i] = 32'd10 + i; b[i] = 32'd20; end
    @(negedge clk);
    chk("post_reset_grant", {30'd0, r1, r0}, 32'd1);
    tick();
    v = 2'b00;
    repeat (4) tick();

    // Randomized traffic with random backpressure and withdrawn requests.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = {v[1] & r1, v[0] & r0};
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !v[i]) begin
          v[i]  = ($urandom % 3) != 0;
          op[i] = ops[$urandom % 8];
          a[i]  = $urandom;
          b[i]  = ($urandom % 5 == 0) ? -a[i] : $urandom;
        end else if ($urandom % 8 == 0) begin
          v[i] = 1'b0;
        end
      end
      rr = {1'($urandom % 4 != 0), 1'($urandom % 4 != 0)};
    end
    v = 2'b00;
    rr = 2'b11;
    repeat (10) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
